// File: rtl/frame_stats.sv
// Frame statistics engine: drains one DEPTH-sample frame from the ping-pong buffer and
// reports signed sum, peak magnitude and first peak index on a valid/ready result port.
module frame_stats #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 buffer_ready_i,
  input  logic [WIDTH-1:0]                     read_data_i,
  input  logic                                 read_valid_i,
  output logic                                 read_ready_o,
  output logic [WIDTH+$clog2(DEPTH)-1:0]       sum_o,
  output logic [WIDTH-1:0]                     peak_abs_o,
  output logic [$clog2(DEPTH)-1:0]             peak_idx_o,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic                                 busy_o,
  output logic                                 overrun_o,
  output logic [15:0]                          frame_count_o
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned SUM_WIDTH  = WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic [WIDTH-1:0]        peak_abs_q, peak_abs_d;
  logic [ADDR_WIDTH-1:0]   peak_idx_q, peak_idx_d;
  logic [15:0]             frame_count_q, frame_count_d;

  logic                    start;
  logic                    xfer;
  logic                    result_hs;
  logic [SUM_WIDTH-1:0]    sample_ext;
  logic [WIDTH-1:0]        sample_abs;

  assign start      = pending_q | buffer_ready_i;
  assign xfer       = (state_q == StRead) & read_valid_i;
  assign result_hs  = (state_q == StDone) & result_ready_i;
  assign sample_ext = {{ADDR_WIDTH{read_data_i[WIDTH-1]}}, read_data_i};
  // Unsigned magnitude: the most negative sample maps to 2^(WIDTH-1) without saturation.
  assign sample_abs = read_data_i[WIDTH-1] ? (~read_data_i + {{(WIDTH-1){1'b0}}, 1'b1})
                                           : read_data_i;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    peak_abs_d    = peak_abs_q;
    peak_idx_d    = peak_idx_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRead;
          pending_d  = 1'b0;
          idx_d      = '0;
          sum_d      = '0;
          peak_abs_d = '0;
          peak_idx_d = '0;
        end
      end

      StRead: begin
        if (buffer_ready_i) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (xfer) begin
          sum_d = sum_q + sample_ext;
          if (sample_abs > peak_abs_q) begin
            peak_abs_d = sample_abs;
            peak_idx_d = idx_q;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == ADDR_WIDTH'(DEPTH - 1)) state_d = StDone;
        end
      end

      StDone: begin
        if (result_hs) begin
          frame_count_d = frame_count_q + 16'd1;
          if (start) begin
            state_d    = StRead;
            // A pulse arriving while pending is consumed re-arms pending instead of overrunning.
            pending_d  = pending_q & buffer_ready_i;
            idx_d      = '0;
            sum_d      = '0;
            peak_abs_d = '0;
            peak_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (buffer_ready_i) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      idx_q         <= '0;
      sum_q         <= '0;
      peak_abs_q    <= '0;
      peak_idx_q    <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      peak_abs_q    <= peak_abs_d;
      peak_idx_q    <= peak_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign read_ready_o   = (state_q == StRead);
  assign result_valid_o = (state_q == StDone);
  assign busy_o         = (state_q != StIdle);
  assign overrun_o      = overrun_q;
  assign sum_o          = sum_q;
  assign peak_abs_o     = peak_abs_q;
  assign peak_idx_o     = peak_idx_q;
  assign frame_count_o  = frame_count_q;

endmodule

// File: tb/tb_frame_stats.sv
// Directed bench for frame_stats: sample queue driver, frame-level statistics model and a
// per-cycle result checker, plus literal expectations for each directed frame.
module tb_frame_stats;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int SW = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          buffer_ready_i;
  logic [W-1:0]  read_data_i;
  logic          read_valid_i;
  logic          read_ready_o;
  logic [SW-1:0] sum_o;
  logic [W-1:0]  peak_abs_o;
  logic [AW-1:0] peak_idx_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;
  logic          overrun_o;
  logic [15:0]   frame_count_o;

  frame_stats #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .buffer_ready_i (buffer_ready_i),
    .read_data_i    (read_data_i),
    .read_valid_i   (read_valid_i),
    .read_ready_o   (read_ready_o),
    .sum_o          (sum_o),
    .peak_abs_o     (peak_abs_o),
    .peak_idx_o     (peak_idx_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .frame_count_o  (frame_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int sum; int peak; int idx;} rec_t;
  typedef logic [W-1:0] frame_t [D];

  logic [W-1:0] sq[$];
  rec_t         eq[$];
  int  tests = 0;
  int  fails = 0;
  int  exp_fc = 0;
  bit  exp_ovr = 1'b0;
  int  xfer_cnt = 0;
  int  vcount = 0;
  bit  gap_en = 1'b0;
  bit  xfer_now = 1'b0;
  bit  hs_now = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Frame statistics straight from the definition, over plain integers.
  function automatic rec_t model(input frame_t f);
    rec_t r;
    r.sum = 0; r.peak = 0; r.idx = 0;
    for (int i = 0; i < D; i++) begin
      int s;
      int a;
      s = $signed(f[i]);
      a = (s < 0) ? -s : s;
      r.sum += s;
      if (a > r.peak) begin
        r.peak = a;
        r.idx  = i;
      end
    end
    return r;
  endfunction

  task automatic load_frame(input frame_t f, input bit expect_result);
    for (int i = 0; i < D; i++) sq.push_back(f[i]);
    if (expect_result) eq.push_back(model(f));
  endtask

  task automatic pulse();
    @(posedge clk_i); #1 buffer_ready_i = 1'b1;
    @(posedge clk_i); #1 buffer_ready_i = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!result_valid_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_timeout"}, result_valid_o, 1);
  endtask

  task automatic do_reset();
    exp_ovr = 1'b0;
    exp_fc  = 0;
    rst_i   = 1'b1;
    sq.delete();
    eq.delete();
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  // Sample driver and model bookkeeping; handshakes are latched on the preceding negedge.
  initial begin
    read_valid_i = 1'b0;
    read_data_i  = '0;
    forever begin
      @(posedge clk_i);
      if (xfer_now && sq.size() > 0) begin
        void'(sq.pop_front());
        xfer_cnt++;
      end
      if (hs_now) begin
        if (eq.size() > 0) void'(eq.pop_front());
        exp_fc++;
      end
      #1;
      read_valid_i = (sq.size() > 0) && (!gap_en || ($urandom_range(0, 9) < 6));
      read_data_i  = (sq.size() > 0) ? sq[0] : '0;
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk_i);
      xfer_now = read_valid_i & read_ready_o;
      hs_now   = result_valid_o & result_ready_i;
      if (!rst_i) begin
        check("frame_count", frame_count_o, exp_fc);
        check("overrun", overrun_o, exp_ovr);
        if (result_valid_o) begin
          vcount++;
          check("result_expected", eq.size() > 0, 1);
          if (eq.size() > 0) begin
            check("sum", $signed(sum_o), eq[0].sum);
            check("peak_abs", peak_abs_o, eq[0].peak);
            check("peak_idx", peak_idx_o, eq[0].idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    frame_t g;
    int n;
    rst_i          = 1'b1;
    buffer_ready_i = 1'b0;
    result_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_read_ready", read_ready_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_fc", frame_count_o, 0);
    rst_i = 1'b0;

    // Ramp frame, continuous valid.
    for (int i = 0; i < D; i++) f[i] = 16'h0100 + 16'(i);
    load_frame(f, 1'b1);
    vcount = 0;
    pulse();
    check("t1_busy", busy_o, 1);
    wait_result("t1");
    repeat (3) @(negedge clk_i);
    check("t1_valid_cycles", vcount, 1);
    check("t1_sum", sum_o, 20'h01078);
    check("t1_peak", peak_abs_o, 16'h010F);
    check("t1_idx", peak_idx_o, 15);
    check("t1_fc", frame_count_o, 1);
    check("t1_idle", busy_o, 0);

    // Most negative sample at index 3.
    for (int i = 0; i < D; i++) f[i] = 16'h0001;
    f[3] = 16'h8000;
    load_frame(f, 1'b1);
    pulse();
    wait_result("t2");
    check("t2_sum", $signed(sum_o), -32753);
    check("t2_peak", peak_abs_o, 32768);
    check("t2_idx", peak_idx_o, 3);
    repeat (3) @(negedge clk_i);

    // Equal magnitudes: earlier index wins.
    for (int i = 0; i < D; i++) f[i] = 16'h0000;
    f[2] = 16'h0005;
    f[9] = 16'hFFFB;
    load_frame(f, 1'b1);
    pulse();
    wait_result("t3");
    check("t3_sum", $signed(sum_o), 0);
    check("t3_peak", peak_abs_o, 5);
    check("t3_idx", peak_idx_o, 2);
    repeat (3) @(negedge clk_i);

    // Gappy read_valid; an extra queued sample must not be taken.
    gap_en = 1'b1;
    for (int i = 0; i < D; i++) f[i] = 16'h0200 + 16'(i);
    load_frame(f, 1'b1);
    sq.push_back(16'hAAAA);
    xfer_cnt = 0;
    pulse();
    wait_result("t4");
    check("t4_sum", sum_o, 20'h02078);
    check("t4_peak", peak_abs_o, 16'h020F);
    repeat (3) @(negedge clk_i);
    check("t4_xfers", xfer_cnt, 16);
    check("t4_queue_drained", eq.size(), 0);
    sq.delete();
    gap_en = 1'b0;

    // Stalled result, pending pulse, dropped pulse, back-to-back second frame.
    do_reset();
    result_ready_i = 1'b0;
    for (int i = 0; i < D; i++) f[i] = 16'(i * 3 - 20);
    for (int i = 0; i < D; i++) g[i] = 16'h0010 << (i % 4);
    load_frame(f, 1'b1);
    load_frame(g, 1'b1);
    pulse();
    wait_result("t5a");
    pulse();
    check("t5_no_overrun_yet", overrun_o, 0);
    repeat (2) @(posedge clk_i);
    pulse();
    exp_ovr = 1'b1;
    check("t5_overrun", overrun_o, 1);
    repeat (24) @(posedge clk_i);
    #1 result_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t5_b2b_read_ready", read_ready_o, 1);
    check("t5_b2b_valid_low", result_valid_o, 0);
    check("t5_b2b_busy", busy_o, 1);
    wait_result("t5b");
    repeat (3) @(negedge clk_i);
    check("t5_fc", frame_count_o, 2);
    check("t5_overrun_sticky", overrun_o, 1);

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    for (int i = 0; i < D; i++) g[i] = 16'h7000;
    load_frame(g, 1'b0);
    xfer_cnt = 0;
    pulse();
    n = 0;
    while (xfer_cnt < 8 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_partial_xfers", xfer_cnt, 8);
    #1;
    exp_ovr = 1'b0;
    exp_fc  = 0;
    rst_i   = 1'b1;
    sq.delete();
    eq.delete();
    #1;
    check("t6_rst_read_ready", read_ready_o, 0);
    check("t6_rst_valid", result_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_overrun", overrun_o, 0);
    check("t6_rst_sum", sum_o, 0);
    check("t6_rst_peak", peak_abs_o, 0);
    check("t6_rst_idx", peak_idx_o, 0);
    check("t6_rst_fc", frame_count_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    for (int i = 0; i < D; i++) f[i] = 16'(i - 8);
    load_frame(f, 1'b1);
    pulse();
    wait_result("t6");
    check("t6_sum", $signed(sum_o), -8);
    check("t6_peak", peak_abs_o, 8);
    check("t6_idx", peak_idx_o, 0);
    repeat (3) @(negedge clk_i);
    check("t6_fc", frame_count_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
